// File: rtl/control_unit_if.sv
// Control-unit <-> datapath/memory bundle for the 16-bit multicycle CPU.
// Handshake: MemRead/MemWrite are requests held, together with their address controls, until MemReady=1 completes them.
interface control_unit_if;
    logic [15:0] Instruction;
    logic        MemReady;
    logic        Zero;
    logic [2:0]  RS;
    logic [2:0]  RT;
    logic [2:0]  RD;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic        ALUSrc;
    logic        MemToReg;
    logic [15:0] Imm;
    logic [11:0] JumpTarget;
    logic        IllegalOp;

    modport master (
        input  Instruction, MemReady, Zero,
        output RS, RT, RD, RegWrite, MemRead, MemWrite, IRWrite, PCWrite,
               PCSrc, ALUOp, ALUSrc, MemToReg, Imm, JumpTarget, IllegalOp
    );

    modport slave (
        output Instruction, MemReady, Zero,
        input  RS, RT, RD, RegWrite, MemRead, MemWrite, IRWrite, PCWrite,
               PCSrc, ALUOp, ALUSrc, MemToReg, Imm, JumpTarget, IllegalOp
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM: latches each fetched instruction and sequences
// fetch / decode / execute / memory / writeback for the 16-bit CPU.
module control_unit (
    input  logic                  Clock,
    input  logic                  Reset,
    control_unit_if.master        bus,
    output logic [3:0]            dbg_state
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_J     = 4'd5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic        mem_read, mem_write, ir_write, pc_write;
    logic        reg_write, mem_to_reg, alu_src, illegal_op;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;

    assign opcode = ir_q[15:12];
    assign funct  = ir_q[2:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    ir_d     = bus.Instruction;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op  = funct;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src = 1'b1;
                state_d = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src = 1'b1;
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            // ALU operand select and op stay at their execute values so the
            // memory address and writeback result remain stable.
            S_MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                if (bus.MemReady) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                if (bus.MemReady) state_d = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                if (opcode == OP_RTYPE) alu_op = funct;
                else                    alu_src = 1'b1;
                state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                if (bus.Zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUOp      = alu_op;
    assign bus.ALUSrc     = alu_src;
    assign bus.RegWrite   = reg_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.IllegalOp  = illegal_op;

    assign bus.RS         = ir_q[11:9];
    assign bus.RT         = ir_q[8:6];
    assign bus.RD         = (opcode == OP_RTYPE) ? ir_q[5:3] :
                            ((opcode == OP_ADDI) || (opcode == OP_LW)) ? ir_q[8:6] : 3'd0;
    assign bus.Imm        = {{10{ir_q[5]}}, ir_q[5:0]};
    assign bus.JumpTarget = ir_q[11:0];

    assign dbg_state      = state_q;
endmodule
